led_store_bridge: RTL and testbench

Upstream feeder for the LED driver. Accepts CPU store requests on the MMIO bus, decodes the LED window (0xFFFFFC60–0xFFFFFC63), splits each accepted store into byte beats, and queues them in a small posted-write FIFO. The FIFO drains one beat per cycle onto the driver's chip-select, write, address and data inputs, and stalls the CPU only when the queue lacks room.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/beat_fifo.sv | 65 ++++++
 rtl/led_store_bridge.sv | 109 ++++++++++
 tb/tb_led_store_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared MMIO definitions for the peripheral bridges: window base addresses,
// CPU access-size encodings and the byte-beat record queued toward the
// LED driver.
package mmio_pkg;

    localparam logic [31:0] LED_BASE    = 32'hFFFF_FC60;
    localparam logic [31:0] SWITCH_BASE = 32'hFFFF_FC70;
    localparam logic [31:0] SEG_BASE    = 32'hFFFF_FC00;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } beat_t;

endpackage

// File: rtl/beat_fifo.sv
// beat_fifo
// Synchronous FIFO of LED beats with a dual push port (0, 1 or 2 beats per
// edge, pushed in order push0 then push1) and a single pop.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   push_n        number of beats pushed this edge (0..2)
//   push0, push1  beats to push
//   pop           remove the head beat this edge (ignored when empty)
//   count         current occupancy, 0..DEPTH
//   head          beat at the read pointer (valid when count != 0)
module beat_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push_n,
    input  beat_t                    push0,
    input  beat_t                    push1,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output beat_t                    head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    beat_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, wr_p1;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_pop;

    // Pointers are exactly AW bits wide, so the adds wrap modulo DEPTH.
    always_comb begin
        do_pop = pop && (cnt_q != '0);
        wr_p1  = wr_q + 1'b1;
        wr_d   = wr_q + AW'(push_n);
        rd_d   = rd_q + AW'(do_pop);
        cnt_d  = cnt_q + CW'(push_n) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the cleared count makes old contents invisible.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem_q[wr_q]  <= push0;
        if (push_n == 2'd2) mem_q[wr_p1] <= push1;
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/led_store_bridge.sv
// led_store_bridge
// Decodes CPU stores to the LED window, splits them into byte beats, queues
// them in a posted-write FIFO and drains one beat per cycle to the LED driver.
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   cpu_addr/wdata/write/size   CPU store request (held until accepted)
//   cpu_stall                   combinational: request not accepted this cycle
//   ledcs/ledwrite              registered strobe, high one cycle per beat
//   ledaddr/ledinputdata        registered byte select and byte
//   pending                     FIFO occupancy
//   access_err                  sticky flag for illegal stores into the window
module led_store_bridge
    import mmio_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] LED_BASE = mmio_pkg::LED_BASE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    input  logic                    cpu_write,
    input  logic [1:0]              cpu_size,
    output logic                    cpu_stall,
    output logic                    ledcs,
    output logic                    ledwrite,
    output logic [1:0]              ledaddr,
    output logic [7:0]              ledinputdata,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    access_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic           hit, legal;
    logic [1:0]     n_beats, push_n;
    beat_t          b0, b1, head;
    logic [CW-1:0]  count, free;
    logic           pop;
    logic           err_d, err_q;
    logic           cs_d, cs_q;
    logic [1:0]     addr_d, addr_q;
    logic [7:0]     data_d, data_q;
    logic           unused_wdata;

    assign unused_wdata = ^cpu_wdata[31:16];

    always_comb begin
        hit     = cpu_write && (cpu_addr[31:2] == LED_BASE[31:2]);
        legal   = 1'b0;
        n_beats = 2'd0;
        b0      = '{addr: 2'b00, data: cpu_wdata[7:0]};
        b1      = '{addr: 2'b10, data: cpu_wdata[15:8]};
        case ({cpu_size, cpu_addr[1:0]})
            {SZ_BYTE, 2'b00}: begin legal = 1'b1; n_beats = 2'd1; end
            {SZ_BYTE, 2'b10}: begin legal = 1'b1; n_beats = 2'd1; b0.addr = 2'b10; end
            {SZ_HALF, 2'b00},
            {SZ_WORD, 2'b00}: begin legal = 1'b1; n_beats = 2'd2; end
            {SZ_HALF, 2'b10}: begin legal = 1'b1; n_beats = 2'd1; b0.addr = 2'b10; end
            default:          ;
        endcase
    end

    // Room is judged on occupancy before this edge's pop, so cpu_stall never
    // depends on the drain path.
    always_comb begin
        free      = CW'(DEPTH) - count;
        cpu_stall = hit && legal && (free < CW'(n_beats));
        push_n    = (hit && legal && !cpu_stall && !rst) ? n_beats : 2'd0;
        err_d     = err_q | (hit && !legal);
        pop       = (count != '0);
        cs_d      = pop;
        addr_d    = pop ? head.addr : addr_q;
        data_d    = pop ? head.data : data_q;
    end

    beat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_n (push_n),
        .push0  (b0),
        .push1  (b1),
        .pop    (pop),
        .count  (count),
        .head   (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= 1'b0;
            addr_q <= 2'b00;
            data_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            cs_q   <= cs_d;
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    assign ledcs        = cs_q;
    assign ledwrite     = cs_q;
    assign ledaddr      = addr_q;
    assign ledinputdata = data_q;
    assign pending      = count;
    assign access_err   = err_q;

endmodule

// File: tb/tb_led_store_bridge.sv
module tb_led_store_bridge;

    localparam int DEPTH = 4;
    localparam logic [31:0] LED = 32'hFFFF_FC60;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_write;
    logic [1:0]  cpu_size;
    logic        cpu_stall, ledcs, ledwrite, access_err;
    logic [1:0]  ledaddr;
    logic [7:0]  ledinputdata;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_store_bridge #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_write    (cpu_write),
        .cpu_size     (cpu_size),
        .cpu_stall    (cpu_stall),
        .ledcs        (ledcs),
        .ledwrite     (ledwrite),
        .ledaddr      (ledaddr),
        .ledinputdata (ledinputdata),
        .pending      (pending),
        .access_err   (access_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_write = 1'b0;
        cpu_addr  = 32'h0;
        cpu_size  = 2'b00;
        cpu_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Holds a request until accepted; returns after the accepting edge (+1).
    task automatic send(input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, output int stalls);
        stalls    = 0;
        cpu_addr  = a;
        cpu_size  = s;
        cpu_wdata = d;
        cpu_write = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_stall) begin
                tick();
                return;
            end
            stalls++;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout addr %h stalled %0d cycles, want acceptance", a, stalls);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        cpu_write = 1'b1;
        cpu_addr  = LED;
        cpu_wdata = 32'h0000_00FF;
        tick();
        tick();
        checks++; if (ledcs !== 1'b0 || ledwrite !== 1'b0) begin errors++; $display("FAIL reset_cs got %b/%b want 0/0", ledcs, ledwrite); end
        checks++; if (ledaddr !== 2'b00 || ledinputdata !== 8'h00) begin errors++; $display("FAIL reset_data got %b/%h want 00/00", ledaddr, ledinputdata); end
        checks++; if (pending !== 3'd0 || access_err !== 1'b0) begin errors++; $display("FAIL reset_state got pend %0d err %b want 0/0", pending, access_err); end
        idle();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (ledcs !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL reset_req_dropped got cs %b pend %0d want 0/0", ledcs, pending); end
    endtask

    task automatic test_byte();
        int st;
        send(LED, 2'b00, 32'h0000_00A5, st);
        idle();
        checks++; if (st != 0) begin errors++; $display("FAIL byte_stall got %0d want 0", st); end
        checks++; if (pending !== 3'd1 || ledcs !== 1'b0) begin errors++; $display("FAIL byte_queued got pend %0d cs %b want 1/0", pending, ledcs); end
        tick();
        checks++; if (ledcs !== 1'b1 || ledwrite !== 1'b1 || ledaddr !== 2'b00 || ledinputdata !== 8'hA5)
            begin errors++; $display("FAIL byte_out got cs %b wr %b a %b d %h want 1 1 00 a5", ledcs, ledwrite, ledaddr, ledinputdata); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL byte_pend got %0d want 0", pending); end
        tick();
        checks++; if (ledcs !== 1'b0 || ledinputdata !== 8'hA5) begin errors++; $display("FAIL byte_end got cs %b d %h want 0 a5", ledcs, ledinputdata); end
    endtask

    task automatic test_word_split();
        int st;
        send(LED, 2'b10, 32'h1234_5678, st);
        idle();
        checks++; if (st != 0 || pending !== 3'd2) begin errors++; $display("FAIL word_push got stall %0d pend %0d want 0/2", st, pending); end
        tick();
        checks++; if (ledcs !== 1'b1 || ledaddr !== 2'b00 || ledinputdata !== 8'h78 || pending !== 3'd1)
            begin errors++; $display("FAIL word_beat0 got cs %b a %b d %h p %0d want 1 00 78 1", ledcs, ledaddr, ledinputdata, pending); end
        tick();
        checks++; if (ledcs !== 1'b1 || ledaddr !== 2'b10 || ledinputdata !== 8'h56 || pending !== 3'd0)
            begin errors++; $display("FAIL word_beat1 got cs %b a %b d %h p %0d want 1 10 56 0", ledcs, ledaddr, ledinputdata, pending); end
        tick();
        checks++; if (ledcs !== 1'b0) begin errors++; $display("FAIL word_end got cs %b want 0", ledcs); end
    endtask

    // Fills the queue so the final half store must wait for two free slots.
    task automatic test_back_to_back();
        logic [9:0] exp_b [7] = '{10'h011, 10'h222, 10'h033, 10'h244, 10'h255, 10'h066, 10'h277};
        logic [9:0] got [$];
        int st_h, st0, first, last, wr_bad;
        first = -1; last = -1; wr_bad = 0;
        fork
            begin
                send(LED,          2'b10, 32'h0000_2211, st0);
                send(LED,          2'b10, 32'h0000_4433, st0);
                send(LED + 32'd2,  2'b00, 32'h0000_0055, st0);
                send(LED,          2'b01, 32'h0000_7766, st_h);
                idle();
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    @(negedge clk);
                    if (ledwrite !== ledcs) wr_bad++;
                    if (ledcs === 1'b1) begin
                        got.push_back({ledaddr, ledinputdata});
                        if (first < 0) first = c;
                        last = c;
                    end
                end
            end
        join
        checks++; if (st_h != 1) begin errors++; $display("FAIL full_stall_cycles got %0d want 1", st_h); end
        checks++; if (got.size() != 7) begin errors++; $display("FAIL full_beat_count got %0d want 7", got.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= got.size()) begin errors++; $display("FAIL full_beat%0d got none want %h", i, exp_b[i]); end
            else if (got[i] !== exp_b[i]) begin errors++; $display("FAIL full_beat%0d got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++; if (last - first != 6) begin errors++; $display("FAIL b2b_continuous got span %0d want 6", last - first); end
        checks++; if (wr_bad != 0) begin errors++; $display("FAIL ledwrite_eq_cs got %0d diffs want 0", wr_bad); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", pending); end
    endtask

    task automatic test_illegal();
        int st, seen;
        do_reset();
        send(LED + 32'd1, 2'b00, 32'h0000_0011, st);
        idle();
        checks++; if (st != 0 || access_err !== 1'b1 || pending !== 3'd0)
            begin errors++; $display("FAIL ill_byte got stall %0d err %b pend %0d want 0 1 0", st, access_err, pending); end
        send(LED + 32'd2, 2'b10, 32'h1122_3344, st);
        idle();
        checks++; if (st != 0 || access_err !== 1'b1 || pending !== 3'd0)
            begin errors++; $display("FAIL ill_word got stall %0d err %b pend %0d want 0 1 0", st, access_err, pending); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (ledcs !== 1'b0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL ill_nobeat got %0d beats want 0", seen); end
        send(LED + 32'd2, 2'b00, 32'h0000_003C, st);
        idle();
        tick();
        checks++; if (ledcs !== 1'b1 || ledaddr !== 2'b10 || ledinputdata !== 8'h3C || access_err !== 1'b1)
            begin errors++; $display("FAIL ill_then_legal got cs %b a %b d %h err %b want 1 10 3c 1", ledcs, ledaddr, ledinputdata, access_err); end
        tick();
    endtask

    task automatic test_miss();
        int st;
        send(32'h1001_0000, 2'b10, 32'hDEAD_BEEF, st);
        idle();
        checks++; if (st != 0 || pending !== 3'd0 || access_err !== 1'b1)
            begin errors++; $display("FAIL miss got stall %0d pend %0d err %b want 0 0 1", st, pending, access_err); end
        tick();
        checks++; if (ledcs !== 1'b0) begin errors++; $display("FAIL miss_nobeat got cs %b want 0", ledcs); end
    endtask

    task automatic test_reserved_size();
        int st;
        do_reset();
        checks++; if (access_err !== 1'b0) begin errors++; $display("FAIL rsv_pre got err %b want 0", access_err); end
        send(LED, 2'b11, 32'h0000_00AA, st);
        idle();
        checks++; if (st != 0 || access_err !== 1'b1 || pending !== 3'd0)
            begin errors++; $display("FAIL rsv_size got stall %0d err %b pend %0d want 0 1 0", st, access_err, pending); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        int st, seen;
        do_reset();
        send(LED + 32'd3, 2'b00, 32'h0000_0001, st);
        send(LED, 2'b10, 32'h0000_BBAA, st);
        send(LED, 2'b10, 32'h0000_DDCC, st);
        idle();
        checks++; if (pending !== 3'd3 || access_err !== 1'b1 || ledinputdata !== 8'hAA)
            begin errors++; $display("FAIL mid_pre got pend %0d err %b d %h want 3 1 aa", pending, access_err, ledinputdata); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (ledcs !== 1'b0 || pending !== 3'd0 || ledinputdata !== 8'h00 || ledaddr !== 2'b00 || access_err !== 1'b0)
            begin errors++; $display("FAIL mid_reset got cs %b p %0d d %h a %b err %b want 0 0 00 00 0", ledcs, pending, ledinputdata, ledaddr, access_err); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (ledcs !== 1'b0) seen++; end
        checks++; if (seen != 0 || pending !== 3'd0) begin errors++; $display("FAIL mid_stale got %0d beats pend %0d want 0 0", seen, pending); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte();
        test_word_split();
        test_back_to_back();
        test_illegal();
        test_miss();
        test_reserved_size();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
